// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - pipeline hazard/flush/halt sequencing controller for the 5-stage datapath
module hazard_sequencer #(
    parameter logic [3:0] OP_LBU   = 4'b0100,
    parameter logic [3:0] OP_LW    = 4'b0110,
    parameter logic [3:0] OP_ATYPE = 4'b0001,
    parameter logic [3:0] OP_HALT  = 4'b1111,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [3:0]       ex_opcode,
    input  logic [3:0]       ex_rd,
    input  logic             ex_overflow,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_kill,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t           state;
    logic [1:0]       drain_cnt;
    logic [CNT_W-1:0] stall_q;

    logic ovf_hit;
    logic halt_hit;
    logic load_use_hit;

    assign ovf_hit  = (ex_opcode == OP_ATYPE) && ex_overflow;
    assign halt_hit = (id_opcode == OP_HALT);
    // r0 is hardwired zero, so a load targeting it can never create a dependency
    assign load_use_hit = ((ex_opcode == OP_LBU) || (ex_opcode == OP_LW)) && (ex_rd != 4'd0) &&
                          ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    assign stall_count = stall_q;

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_kill  = 1'b0;
        halted      = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    if (ovf_hit) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_kill  = 1'b1;
                    end else if (halt_hit || load_use_hit) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                        ifid_flush = branch_taken;
                    end
                end
                DRAIN: begin
                    idex_bubble = 1'b1;
                end
                HALTED: begin
                    idex_bubble = 1'b1;
                    halted      = 1'b1;
                end
                default: begin
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            stall_q   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (ovf_hit) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd2;
                    end else if (halt_hit) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd3;
                    end else if (load_use_hit) begin
                        if (stall_q != {CNT_W{1'b1}}) begin
                            stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) begin
                        state <= HALTED;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - scoreboard bench for hazard_sequencer against a behavioural model
module tb_hazard_sequencer;

    localparam logic [3:0] LBU   = 4'b0100;
    localparam logic [3:0] LW    = 4'b0110;
    localparam logic [3:0] ATYPE = 4'b0001;
    localparam logic [3:0] HALT  = 4'b1111;
    localparam logic [3:0] NOP   = 4'b0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  id_opcode = '0, id_rs1 = '0, id_rs2 = '0;
    logic        id_uses_rs2 = 1'b0;
    logic [3:0]  ex_opcode = '0, ex_rd = '0;
    logic        ex_overflow = 1'b0, branch_taken = 1'b0;
    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_kill, halted;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_overflow(ex_overflow), .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_kill(exmem_kill), .halted(halted),
        .stall_count(stall_count)
    );

    // expected word: {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_kill, halted, stall_count}
    logic [21:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    // model: mode 0 = running, 1 = draining (left cycles remain), 2 = halted
    int mode = 0;
    int left = 0;
    int stalls = 0;

    task automatic apply(input logic rn, input logic [3:0] iop, input logic [3:0] r1, input logic [3:0] r2,
                         input logic u2, input logic [3:0] eop, input logic [3:0] erd,
                         input logic ov, input logic br);
        logic [21:0] e;
        logic ovh, hh, luh;
        rst_n = rn; id_opcode = iop; id_rs1 = r1; id_rs2 = r2; id_uses_rs2 = u2;
        ex_opcode = eop; ex_rd = erd; ex_overflow = ov; branch_taken = br;
        e = '0;
        if (!rn) begin
            mode = 0; left = 0; stalls = 0;
        end else begin
            e[15:0] = stalls[15:0];
            ovh = (eop == ATYPE) && ov;
            hh  = (iop == HALT);
            luh = ((eop == LW) || (eop == LBU)) && (erd != 4'd0) && ((erd == r1) || (u2 && (erd == r2)));
            if (mode == 0) begin
                if (ovh) begin
                    e[21:16] = 6'b001110; mode = 1; left = 2;
                end else if (hh) begin
                    e[21:16] = 6'b000100; mode = 1; left = 3;
                end else if (luh) begin
                    e[21:16] = 6'b000100;
                    if (stalls < 65535) stalls++;
                end else if (br) begin
                    e[21:16] = 6'b111000;
                end else begin
                    e[21:16] = 6'b110000;
                end
            end else begin
                e[21:16] = {5'b00010, (mode == 2) ? 1'b1 : 1'b0};
                if (mode == 1) begin
                    if (left == 1) mode = 2;
                    else left--;
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic rn, input logic [3:0] iop, input logic [3:0] r1, input logic [3:0] r2,
                       input logic u2, input logic [3:0] eop, input logic [3:0] erd,
                       input logic ov, input logic br);
        apply(rn, iop, r1, r2, u2, eop, erd, ov, br);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cyc(input logic rn, input int halt_odds);
        logic [3:0] iop, eop;
        case ($urandom_range(0, 4))
            0: iop = ATYPE; 1: iop = LW; 2: iop = LBU; 3: iop = 4'b0010; default: iop = 4'b1000;
        endcase
        if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) iop = HALT;
        case ($urandom_range(0, 4))
            0: eop = ATYPE; 1: eop = LW; 2: eop = LBU; 3: eop = 4'b0010; default: eop = NOP;
        endcase
        cyc(rn, iop, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            eop, 4'($urandom_range(0, 3)), $urandom_range(0, 29) == 0, 1'($urandom_range(0, 1)));
    endtask

    always @(negedge clk) begin
        logic [21:0] e, act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_kill, halted, stall_count};
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL outputs t=%0t got pc/ifw/fl/bub/kill/hlt=%b cnt=%0d required %b cnt=%0d",
                         $time, act[21:16], act[15:0], e[21:16], e[15:0]);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        cyc(0, NOP, 0, 0, 0, NOP, 0, 0, 0);
        cyc(0, NOP, 0, 0, 0, NOP, 0, 0, 0);
        // load-use stall, then load moves to MEM
        cyc(1, ATYPE, 4'd3, 4'd5, 1, LW, 4'd3, 0, 0);
        cyc(1, ATYPE, 4'd3, 4'd5, 1, NOP, 4'd0, 0, 0);
        // r0 load and unused rs2 never stall
        cyc(1, ATYPE, 4'd0, 4'd0, 1, LW, 4'd0, 0, 0);
        cyc(1, ATYPE, 4'd1, 4'd3, 0, LW, 4'd3, 0, 0);
        cyc(1, ATYPE, 4'd1, 4'd3, 1, LBU, 4'd3, 0, 0);
        // branch alone flushes; branch with load-use only stalls
        cyc(1, 4'b0010, 4'd1, 4'd2, 1, ATYPE, 4'd4, 0, 1);
        cyc(1, 4'b0010, 4'd6, 4'd2, 1, LW, 4'd6, 0, 1);
        // HALT: 3 drain cycles then halted for 25 cycles
        cyc(1, HALT, 4'd0, 4'd0, 0, NOP, 4'd0, 0, 0);
        for (int i = 0; i < 28; i++) rand_cyc(1, 0);
        cyc(0, NOP, 0, 0, 0, NOP, 0, 0, 0);
        // overflow together with HALT takes the overflow path
        cyc(1, HALT, 4'd0, 4'd0, 0, ATYPE, 4'd2, 1, 1);
        for (int i = 0; i < 5; i++) rand_cyc(1, 0);
        // overflow on a non-A-type is ignored
        cyc(0, NOP, 0, 0, 0, NOP, 0, 0, 0);
        cyc(1, ATYPE, 4'd1, 4'd2, 1, LW, 4'd9, 1, 0);
        // reset pulse mid-drain after a stall
        cyc(1, ATYPE, 4'd7, 4'd2, 1, LW, 4'd7, 0, 0);
        cyc(1, HALT, 4'd0, 4'd0, 0, NOP, 4'd0, 0, 0);
        cyc(1, ATYPE, 4'd1, 4'd2, 1, NOP, 4'd0, 0, 0);
        cyc(0, ATYPE, 4'd1, 4'd2, 1, NOP, 4'd0, 0, 0);
        cyc(1, ATYPE, 4'd1, 4'd2, 1, NOP, 4'd0, 0, 0);
        cyc(1, 4'b0010, 4'd1, 4'd2, 1, NOP, 4'd0, 0, 1);
        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ((mode == 2 && $urandom_range(0, 5) == 0) || $urandom_range(0, 149) == 0)
                rand_cyc(0, 40);
            else
                rand_cyc(1, 40);
        end
        // stall counter saturation
        cyc(0, NOP, 0, 0, 0, NOP, 0, 0, 0);
        for (int i = 0; i < 65540; i++) cyc(1, ATYPE, 4'd5, 4'd1, 0, LW, 4'd5, 0, 0);
        cyc(1, ATYPE, 4'd1, 4'd2, 1, NOP, 4'd0, 0, 1);
        cyc(1, ATYPE, 4'd1, 4'd2, 1, NOP, 4'd0, 0, 0);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
